// File: rtl/playback_if.sv
// Bus bundle between the playback engine and its environment: control inputs,
// the ZBT read port and the AC97 sample path.
interface playback_if #(
  parameter int ADDR_W = 19
);
  logic              play;
  logic              loop;
  logic              ready;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] length;
  logic [35:0]       zbt_data;
  logic [ADDR_W-1:0] address;
  logic              we_ZBT;
  logic [7:0]        to_ac97_data;
  logic              playing;
  logic              playback_done;

  modport master (
    output play, loop, ready, start_addr, length, zbt_data,
    input  address, we_ZBT, to_ac97_data, playing, playback_done
  );

  modport slave (
    input  play, loop, ready, start_addr, length, zbt_data,
    output address, we_ZBT, to_ac97_data, playing, playback_done
  );
endinterface

// File: rtl/playback.sv
// Streams decimated 8-bit PCM words from ZBT to AC97, rebuilding four output
// frames per stored word by linear interpolation towards the following word.
module playback #(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 19
) (
  input logic       clock,
  input logic       reset_n,
  playback_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    PLAY   = 3'd3,
    REFILL = 3'd4
  } state_t;

  localparam logic [3:0]        LAT      = 4'(READ_LATENCY);
  localparam logic [ADDR_W:0]   IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // s0 + floor((s1 - s0) * phase / 4); the result stays between s0 and s1.
  function automatic logic [7:0] interp(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] ph);
    logic signed [8:0]  diff;
    logic signed [10:0] prod;
    logic signed [10:0] shr;
    diff   = $signed({b[7], b}) - $signed({a[7], a});
    prod   = $signed({{2{diff[8]}}, diff}) * $signed({9'd0, ph});
    shr    = prod >>> 2;
    interp = a + shr[7:0];
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  logic [7:0]        s0_q, s0_d, s1_q, s1_d, out_q, out_d;
  logic [1:0]        phase_q, phase_d;
  logic [3:0]        wait_q, wait_d;
  logic              pending_q, pending_d, playing_q, playing_d, done_q, done_d;

  logic [ADDR_W-1:0] rd_addr_s, next_addr_s;
  logic [ADDR_W:0]   len_ext_s, end_mark_s;
  logic              more_words_s, next_more_s, data_ok_s, fire_s;
  logic              zbt_unused;

  assign zbt_unused   = ^bus.zbt_data[35:8];
  assign rd_addr_s    = start_q + rd_idx_q[ADDR_W-1:0];
  assign next_addr_s  = rd_addr_s + ADDR_ONE;
  assign len_ext_s    = {1'b0, len_q};
  assign end_mark_s   = len_ext_s + IDX_ONE;
  assign more_words_s = rd_idx_q < len_ext_s;
  assign next_more_s  = (rd_idx_q + IDX_ONE) < len_ext_s;
  assign data_ok_s    = wait_q == LAT;
  assign fire_s       = bus.ready | pending_q;

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    start_d   = start_q;
    len_d     = len_q;
    rd_idx_d  = rd_idx_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    out_d     = out_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (state_q != IDLE && !bus.play) begin
      state_d   = IDLE;
      pending_d = 1'b0;
    end else begin
      if (bus.ready && (state_q == FETCH0 || state_q == FETCH1 || state_q == REFILL)) begin
        pending_d = 1'b1;
      end else begin
        pending_d = pending_q;
      end
      case (state_q)
        IDLE: begin
          if (bus.play && (bus.length != '0)) begin
            start_d   = bus.start_addr;
            len_d     = bus.length;
            address_d = bus.start_addr;
            rd_idx_d  = '0;
            phase_d   = 2'd0;
            wait_d    = 4'd0;
            pending_d = bus.ready;
            state_d   = FETCH0;
          end else if (bus.ready) begin
            out_d = 8'd0;
          end else begin
            out_d = out_q;
          end
        end
        FETCH0: begin
          wait_d = wait_q + 4'd1;
          if (data_ok_s) begin
            s0_d     = bus.zbt_data[7:0];
            rd_idx_d = rd_idx_q + IDX_ONE;
            wait_d   = 4'd0;
            state_d  = FETCH1;
            // The second read is launched here only if a second word exists.
            if (next_more_s) begin
              address_d = next_addr_s;
            end else begin
              address_d = address_q;
            end
          end else begin
            state_d = FETCH0;
          end
        end
        FETCH1, REFILL: begin
          if (more_words_s) begin
            wait_d = wait_q + 4'd1;
            if (data_ok_s) begin
              s1_d     = bus.zbt_data[7:0];
              rd_idx_d = rd_idx_q + IDX_ONE;
              wait_d   = 4'd0;
              state_d  = PLAY;
            end else begin
              state_d = state_q;
            end
          end else begin
            s1_d     = s0_q;
            rd_idx_d = end_mark_s;
            state_d  = PLAY;
          end
        end
        PLAY: begin
          if (fire_s) begin
            out_d     = interp(s0_q, s1_q, phase_q);
            phase_d   = phase_q + 2'd1;
            pending_d = 1'b0;
            if (phase_q == 2'd3) begin
              if (rd_idx_q == end_mark_s) begin
                if (bus.loop) begin
                  rd_idx_d  = '0;
                  address_d = start_q;
                  wait_d    = 4'd0;
                  state_d   = FETCH0;
                end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                end
              end else begin
                s0_d    = s1_q;
                wait_d  = 4'd0;
                state_d = REFILL;
                if (more_words_s) begin
                  address_d = rd_addr_s;
                end else begin
                  address_d = address_q;
                end
              end
            end else begin
              state_d = PLAY;
            end
          end else begin
            state_d = PLAY;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    playing_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      address_q <= '0;
      start_q   <= '0;
      len_q     <= '0;
      rd_idx_q  <= '0;
      s0_q      <= 8'd0;
      s1_q      <= 8'd0;
      out_q     <= 8'd0;
      phase_q   <= 2'd0;
      wait_q    <= 4'd0;
      pending_q <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      start_q   <= start_d;
      len_q     <= len_d;
      rd_idx_q  <= rd_idx_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      out_q     <= out_d;
      phase_q   <= phase_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign bus.address       = address_q;
  assign bus.we_ZBT        = 1'b1;
  assign bus.to_ac97_data  = out_q;
  assign bus.playing       = playing_q;
  assign bus.playback_done = done_q;

endmodule

// File: tb/tb_playback.sv
// Scoreboard bench for playback: a ZBT model with two-cycle read latency and a
// word-list interpolation model predicting every AC97 sample.
module tb_playback;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  playback_if #(.ADDR_W(19)) bus ();

  playback #(.READ_LATENCY(2), .ADDR_W(19)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  logic [35:0] mem [int];
  logic [35:0] zbt_p1 = 36'd0;
  logic [7:0]  sb_out[$];
  bit          sb_done[$];
  logic [7:0]  frames[$];
  int          addr_log[$];
  int          passed   = 0;
  int          total    = 0;
  int          done_cnt = 0;
  int          we_bad   = 0;
  int          exp_done = 0;

  function automatic logic [35:0] mem_rd(input logic [18:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 36'd0;
  endfunction

  always @(posedge clock) begin
    zbt_p1       <= mem_rd(bus.address);
    bus.zbt_data <= zbt_p1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Each word spans four frames ramping towards the next word; the last word holds.
  function automatic void expand(input logic [7:0] w[$]);
    int a, b, d;
    frames.delete();
    for (int k = 0; k < w.size(); k++) begin
      a = sx(w[k]);
      b = sx(w[(k + 1 < w.size()) ? k + 1 : k]);
      for (int ph = 0; ph < 4; ph++) begin
        d = ((b - a) * ph) >>> 2;
        frames.push_back(8'(a + d));
      end
    end
  endfunction

  task automatic load(input logic [18:0] st, input logic [7:0] w[$]);
    logic [31:0] r;
    logic [18:0] a;
    for (int i = 0; i < w.size(); i++) begin
      r = $urandom();
      a = st + 19'(i);
      mem[int'(a)] = {r[27:0], w[i]};
    end
  endtask

  task automatic start(input logic [18:0] st, input logic [18:0] len, input bit lp);
    @(negedge clock);
    bus.start_addr = st;
    bus.length     = len;
    bus.loop       = lp;
    bus.play       = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic strobe(input logic [7:0] e, input bit ed, input bit drop);
    @(negedge clock);
    bus.ready = 1'b1;
    sb_out.push_back(e);
    sb_done.push_back(ed);
    @(negedge clock);
    bus.ready = 1'b0;
    if (drop) bus.play = 1'b0;
    repeat ($urandom_range(12, 7)) @(negedge clock);
  endtask

  task automatic play_words(input logic [18:0] st, input logic [7:0] w[$]);
    load(st, w);
    expand(w);
    start(st, 19'(w.size()), 1'b0);
    for (int i = 0; i < frames.size(); i++) begin
      strobe(frames[i], i == frames.size() - 1, i == frames.size() - 1);
    end
    exp_done++;
    repeat (4) @(negedge clock);
  endtask

  // Monitor: pops one expectation per sampled ready strobe, tracks side effects.
  initial begin
    logic [18:0] prev;
    logic        r;
    logic [7:0]  e_out;
    bit          e_done;
    prev = 19'd0;
    forever begin
      @(posedge clock);
      r = bus.ready;
      @(negedge clock);
      if (bus.we_ZBT !== 1'b1) we_bad++;
      if (bus.playback_done === 1'b1) done_cnt++;
      if (bus.address !== prev) begin
        addr_log.push_back(int'(bus.address));
        prev = bus.address;
      end
      if (r) begin
        if (sb_out.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e_out  = sb_out.pop_front();
          e_done = sb_done.pop_front();
          chk("sample", int'(bus.to_ac97_data), int'(e_out));
          chk("done_with_sample", int'(bus.playback_done), int'(e_done));
        end
      end
    end
  end

  initial begin
    logic [7:0] w[$];
    logic [7:0] lw[3];
    int         dc;
    bus.play = 1'b0; bus.loop = 1'b0; bus.ready = 1'b0;
    bus.start_addr = 19'd0; bus.length = 19'd0;

    repeat (2) @(negedge clock);
    chk("rst_address", int'(bus.address), 0);
    chk("rst_sample", int'(bus.to_ac97_data), 0);
    chk("rst_playing", int'(bus.playing), 0);
    chk("rst_done", int'(bus.playback_done), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Two words, no loop: address trace and single done pulse.
    addr_log.delete();
    w = '{8'h10, 8'h20};
    mem[int'(19'h102)] = 36'h55;
    start_check: begin
      play_words(19'h100, w);
    end
    chk("t1_addr_count", addr_log.size(), 2);
    chk("t1_addr0", (addr_log.size() > 0) ? addr_log[0] : -1, 32'h100);
    chk("t1_addr1", (addr_log.size() > 1) ? addr_log[1] : -1, 32'h101);
    chk("t1_done_count", done_cnt, exp_done);
    chk("t1_playing_after", int'(bus.playing), 0);

    // Signed ramp through the full range.
    w = '{8'h7F, 8'h80};
    play_words(19'h200, w);
    chk("ramp_done_count", done_cnt, exp_done);

    // Two words starting at the top of memory wrap to address 0.
    addr_log.delete();
    w = '{8'($urandom()), 8'($urandom())};
    play_words(19'h7FFFF, w);
    chk("wrap_addr_count", addr_log.size(), 2);
    chk("wrap_addr0", (addr_log.size() > 0) ? addr_log[0] : -1, 32'h7FFFF);
    chk("wrap_addr1", (addr_log.size() > 1) ? addr_log[1] : -1, 0);

    // Single looping word: refetched each pass, no done pulse.
    addr_log.delete();
    dc = done_cnt;
    for (int p = 0; p < 3; p++) lw[p] = 8'($urandom());
    w = '{lw[0]};
    load(19'h7FFFF, w);
    start(19'h7FFFF, 19'd1, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int ph = 0; ph < 4; ph++) begin
        if (ph == 3 && p < 2) begin
          w = '{lw[p + 1]};
          load(19'h7FFFF, w);
        end
        strobe(lw[p], 1'b0, 1'b0);
      end
    end
    bus.play = 1'b0;
    repeat (4) @(negedge clock);
    chk("loop_done_none", done_cnt, dc);
    chk("loop_addr_count", addr_log.size(), 1);
    chk("loop_addr0", (addr_log.size() > 0) ? addr_log[0] : -1, 32'h7FFFF);

    // Random non-looping recordings.
    for (int t = 0; t < 3; t++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(6, 3)); i++) w.push_back(8'($urandom()));
      play_words(19'($urandom()), w);
    end
    chk("rand_done_count", done_cnt, exp_done);

    // Abort while refilling after word index 4.
    dc = done_cnt;
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back(8'($urandom()));
    load(19'h300, w);
    expand(w);
    start(19'h300, 19'd8, 1'b0);
    for (int i = 0; i < 19; i++) strobe(frames[i], 1'b0, 1'b0);
    @(negedge clock);
    bus.ready = 1'b1;
    sb_out.push_back(frames[19]);
    sb_done.push_back(1'b0);
    @(negedge clock);
    bus.ready = 1'b0;
    bus.play  = 1'b0;
    @(negedge clock);
    chk("abort_idle_next_cycle", int'(bus.playing), 0);
    chk("abort_sample_held", int'(bus.to_ac97_data), int'(frames[19]));
    repeat (5) @(negedge clock);
    strobe(8'h00, 1'b0, 1'b0);
    chk("abort_playing", int'(bus.playing), 0);
    chk("abort_no_done", done_cnt, dc);

    // Asynchronous reset in the middle of a looping pass.
    w = '{8'h33, 8'h99, 8'h44};
    load(19'h400, w);
    expand(w);
    start(19'h400, 19'd3, 1'b1);
    strobe(frames[0], 1'b0, 1'b0);
    strobe(frames[1], 1'b0, 1'b0);
    @(posedge clock);
    #2;
    reset_n  = 1'b0;
    bus.play = 1'b0;
    #1;
    chk("async_rst_address", int'(bus.address), 0);
    chk("async_rst_sample", int'(bus.to_ac97_data), 0);
    chk("async_rst_playing", int'(bus.playing), 0);
    chk("async_rst_done", int'(bus.playback_done), 0);
    chk("async_rst_we", int'(bus.we_ZBT), 1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_playing", int'(bus.playing), 0);

    // Zero length: stays idle and never reads.
    addr_log.delete();
    dc = done_cnt;
    @(negedge clock);
    bus.start_addr = 19'h500;
    bus.length     = 19'd0;
    bus.loop       = 1'b0;
    bus.play       = 1'b1;
    repeat (4) @(negedge clock);
    strobe(8'h00, 1'b0, 1'b0);
    chk("len0_playing", int'(bus.playing), 0);
    chk("len0_no_reads", addr_log.size(), 0);
    chk("len0_no_done", done_cnt, dc);
    bus.play = 1'b0;
    repeat (4) @(negedge clock);

    chk("we_high_throughout", we_bad, 0);
    chk("scoreboard_drained", sb_out.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/playback.md
# playback

Reads 8-bit PCM samples previously stored in ZBT memory by the recording path and streams them to the AC97 headphone output. Each stored word represents 4 AC97 frames, because recording keeps every 4th sample. Playback therefore rebuilds 4 output frames per stored word by linear interpolation between consecutive words. Sits between the ZBT read port and the AC97 `to_ac97_data` mux, alongside the recorder, and shares its address space.

## Interface
- READ_LATENCY, 2: cycles from `address` presented to the matching `zbt_data` being valid.
- ADDR_W, 19: ZBT address width.
- clock  in  1  27 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- play  in  1  level; 1 = run playback, 0 = stop/abort.
- loop  in  1  sampled at the end of the last word; 1 = restart from `start_addr`.
- ready  in  1  one-cycle AC97 frame strobe, about 562 cycles apart.
- start_addr  in  ADDR_W  first ZBT word of the recording; sampled when leaving IDLE.
- length  in  ADDR_W  number of stored words; sampled when leaving IDLE.
- zbt_data  in  36  ZBT read data; the sample is `[7:0]`, signed two's complement, and `[35:8]` is ignored.
- address  out  ADDR_W  ZBT read address.
- we_ZBT  out  1  ZBT write enable, active-low; this block drives it to constant 1 (never writes).
- to_ac97_data  out  8  PCM sample to the headphone path.
- playing  out  1  high in every state except IDLE.
- playback_done  out  1  one-cycle pulse when the last frame of a non-looping pass is emitted.

## Operation
- Reset values (asynchronous): `address`=0, `we_ZBT`=1, `to_ac97_data`=0, `playing`=0, `playback_done`=0, phase=0, `rd_idx`=0, `s0`=`s1`=0, pending=0, state=IDLE.
- States: IDLE, FETCH0, FETCH1, PLAY, REFILL.
- **IDLE**
  - On `play`=1 with `length`≠0: latch `start_addr` and `length`, set `rd_idx`=0, go to FETCH0.
  - With `length`=0 the block stays in IDLE and emits no done pulse.
  - On each `ready` in IDLE: `to_ac97_data` ← 0.
- **FETCH0**: drive `address` = start+`rd_idx`, capture `zbt_data[7:0]` into `s0` READ_LATENCY cycles later, then `rd_idx`+1 and go to FETCH1.
- **FETCH1**
  - If `rd_idx`<length: read the next word into `s1` the same way, then `rd_idx`+1.
  - Otherwise: `s1` ← `s0` without a read.
  - Then go to PLAY.
- **PLAY**, on `ready` (or on entry if pending=1):
  - `to_ac97_data` ← `s0` + (((`s1`−`s0`)·phase) >>> 2), then phase+1.
  - Arithmetic: the difference is 9-bit signed; the product is 11-bit signed; the shift is arithmetic (floor).
  - The result always lies between `s0` and `s1`, so no saturation is required.
- **End of word**, when phase was 3:
  - If `rd_idx` = length+1 (the last word is done):
    - If `loop`=1: go to FETCH0 with `rd_idx`=0.
    - Otherwise: pulse `playback_done` and go to IDLE.
  - Otherwise: go to REFILL.
- **REFILL**
  - `s0` ← `s1`.
  - If `rd_idx`<length: read `s1` from start+`rd_idx`, then `rd_idx`+1.
  - Otherwise: `s1` ← `s0`, and `rd_idx` ← length+1 as the end marker.
  - Then return to PLAY.
- Address arithmetic wraps modulo 2^ADDR_W.
- `ready` arriving in FETCH0, FETCH1 or REFILL sets pending (1 deep). A second such `ready` is dropped.
- `play`=0 in any non-IDLE state:
  - Go to IDLE on the next cycle and discard any in-flight read.
  - No `playback_done` pulse.
  - `to_ac97_data` holds until the next `ready` sets it to 0.

## Timing
- Refill cost is READ_LATENCY+1 cycles. It ends long before the next `ready`, so pending is normally unused.
- `to_ac97_data` updates on the clock edge after `ready` in PLAY, i.e. latency 1.
- `address` is registered and stable for the whole read. `zbt_data` is sampled exactly READ_LATENCY cycles after `address` changes.
- `playback_done` is asserted in the same cycle that the final `to_ac97_data` update is registered.
- The first output frame follows the first `ready` after FETCH1 completes, i.e. 2·(READ_LATENCY+1) cycles after `play` rises.
- `play`=1 and `ready` in the same cycle in IDLE: the block leaves IDLE and the `ready` becomes pending.

## Test plan
- `length`=2, words 0x10, 0x20 at `start_addr`=0x100, `loop`=0, 8 `ready` strobes:
  - Outputs: 0x10, 0x14, 0x18, 0x1C, then 0x20 ×4.
  - `playback_done` pulses exactly once, with the 8th output.
  - `address` sequence: 0x100, 0x101; no read of 0x102.
- Signed ramp, words 0x7F then 0x80 (−128): outputs 0x7F, 0x3F, 0xFF, 0xBF. Checks arithmetic shift and no overflow.
- `length`=1, `start_addr`=0x7FFFF, `loop`=1:
  - Reads 0x7FFFF only; output is a constant sample.
  - Refetches 0x7FFFF every 4 frames; no done pulse.
  - Separately, `length`=2 from 0x7FFFF must read 0x7FFFF then 0x00000 (wrap).
- Drop `play` during REFILL of word 5: IDLE one cycle later, no done pulse, next `ready` gives `to_ac97_data`=0, `playing`=0.
- Assert `reset_n`=0 mid-PLAY, asynchronously: all outputs at reset values before the next clock edge; `we_ZBT`=1 throughout the whole test.
- `length`=0 with `play`=1: stays IDLE, no reads, `playback_done` stays 0.
